seq_pattern_tx: RTL and testbench

//  Serial bit-pattern transmitter, the stimulus end of the 4-in-a-row 0/1 sequence detector.
//  It loads a parallel pattern from the switches and shifts it out MSB-first, one bit per KEY[0] edge.
//  It also tracks the run length of transmitted bits so LEDG shows the detector response expected downstream.
//  It runs as a DE2 top level; the serial output LEDR[0] feeds the detector's data input.

---
 rtl/seq_pkg.sv | 5 +
 rtl/seq_pattern_tx_if.sv | 9 +
 rtl/run_tracker.sv | 28 ++
 rtl/seq_pattern_tx.sv | 94 +++++++++
 tb/tb_seq_pattern_tx.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and defaults for the sequence generator/detector family.
package seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    localparam int RUN_LEN_DEFAULT = 4;
endpackage

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: DE2 board pins (keys, switches, LEDs) seen by the pattern transmitter.
interface seq_pattern_tx_if;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [17:0] LEDR;
    logic [7:0]  LEDG;
    modport master (output KEY, SW, input LEDR, LEDG);
    modport slave (input KEY, SW, output LEDR, LEDG);
endinterface

// File: rtl/run_tracker.sv
// run_tracker: saturating length of the current run of equal bits, flagged at RUN_LEN.
module run_tracker #(
    parameter int RUN_LEN = seq_pkg::RUN_LEN_DEFAULT,
    localparam int RW = $clog2(RUN_LEN) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_bit,
    input  logic          bit_en,
    input  logic          clr,
    output logic [RW-1:0] run,
    output logic          run_flag
);
    logic last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run  <= '0;
            last <= 1'b0;
        end else if (clr) begin
            run <= '0;
        end else if (bit_en) begin
            run  <= (run == '0 || data_bit != last) ? RW'(1) :
                    (run == RW'(RUN_LEN) ? run : run + 1'b1);
            last <= data_bit;
        end
    end
    assign run_flag = (run == RW'(RUN_LEN));
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: loads a switch pattern and shifts it out MSB-first on KEY[0], tracking runs.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RUN_LEN = RUN_LEN_DEFAULT,
    localparam int CW = $clog2(WIDTH),
    localparam int RW = $clog2(RUN_LEN) + 1
) (
    seq_pattern_tx_if.slave io
);
    logic             clk, rst, start, rpt;
    logic [WIDTH-1:0] pat, sreg, sreg_n;
    logic [CW-1:0]    lenm1, cnt, cnt_n;
    logic             tx_bit, tx_bit_n, tx_valid, tx_valid_n, load, emit, run_flag;
    logic [RW-1:0]    unused_run;
    logic             unused_pins;
    state_t           state, state_n;

    assign clk         = io.KEY[0];
    assign rst         = io.SW[0];
    assign pat         = io.SW[8:1];
    assign start       = io.SW[9];
    assign rpt         = io.SW[10];
    assign lenm1       = io.SW[13:11];
    assign unused_pins = &{1'b0, io.KEY[3:1], io.SW[17:14]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
        end else begin
            state    <= state_n;
            sreg     <= sreg_n;
            cnt      <= cnt_n;
            tx_bit   <= tx_bit_n;
            tx_valid <= tx_valid_n;
        end
    end

    always_comb begin
        state_n    = state;
        sreg_n     = sreg;
        cnt_n      = cnt;
        tx_bit_n   = tx_bit;
        tx_valid_n = tx_valid;
        load       = 1'b0;
        emit       = 1'b0;
        case (state)
            IDLE: if (start) begin
                sreg_n  = pat;
                cnt_n   = lenm1;
                load    = 1'b1;
                state_n = SHIFT;
            end
            SHIFT: begin
                emit       = 1'b1;
                tx_bit_n   = sreg[WIDTH-1];
                tx_valid_n = 1'b1;
                sreg_n     = sreg << 1;
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (rpt) begin
                    sreg_n = pat;
                    cnt_n  = lenm1;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                tx_valid_n = 1'b0;
                if (!start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // The tracker sees the bit as it leaves sreg, so its run matches tx_bit after the edge.
    run_tracker #(.RUN_LEN(RUN_LEN)) u_run (
        .clk      (clk),
        .rst      (rst),
        .data_bit (sreg[WIDTH-1]),
        .bit_en   (emit),
        .clr      (load),
        .run      (unused_run),
        .run_flag (run_flag)
    );

    assign io.LEDR = {5'b0, cnt, sreg, tx_valid, tx_bit};
    assign io.LEDG = {4'b0, state == IDLE, state == SHIFT, run_flag, state == DONE};
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: queue-based model of the transmitter plus directed frames with literal checks.
module tb_seq_pattern_tx;
    localparam int RL = 4;
    logic        clk = 1'b0;
    logic [17:0] sw = 18'h1;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    seq_pattern_tx_if io ();
    assign io.KEY = {3'b000, clk};
    assign io.SW  = sw;

    seq_pattern_tx dut (.io(io.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a queue of bits; run is the trailing equal-bit count of everything sent since load.
    int         phase;
    bit         q[$];
    bit         hist[$];
    logic [7:0] m_pat;
    int         k, m_n;
    logic       e_bit, e_val;

    function automatic int trail();
        int n;
        if (hist.size() == 0) return 0;
        n = 1;
        for (int i = hist.size() - 2; i >= 0 && n < RL; i--) begin
            if (hist[i] != hist[hist.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic reload();
        m_pat = sw[8:1];
        m_n   = int'(sw[13:11]) + 1;
        k     = 0;
        q.delete();
        for (int i = 0; i < m_n; i++) q.push_back(m_pat[7-i]);
    endtask

    always @(negedge clk) begin
        logic [15:0] sh;
        logic [17:0] ledr_e;
        logic [7:0]  ledg_e;
        int          c;
        if (sw[0]) begin
            phase = 0; q.delete(); hist.delete();
            m_pat = 8'h00; k = 0; m_n = 1; e_bit = 1'b0; e_val = 1'b0;
        end else if (phase == 0) begin
            if (sw[9]) begin
                reload();
                hist.delete();
                phase = 1;
            end
        end else if (phase == 1) begin
            e_bit = q.pop_front();
            e_val = 1'b1;
            hist.push_back(e_bit);
            k++;
            if (q.size() == 0) begin
                if (sw[10]) reload();
                else phase = 2;
            end
        end else begin
            e_val = 1'b0;
            if (!sw[9]) phase = 0;
        end
        sh = {8'h00, m_pat} << k;
        c  = m_n - 1 - k;
        if (c < 0) c = 0;
        ledr_e = {5'b0, c[2:0], sh[7:0], e_val, e_bit};
        ledg_e = {4'b0, phase == 0, phase == 1, trail() == RL, phase == 2};
        chk("ledr", 32'(io.LEDR), 32'(ledr_e));
        chk("ledg", 32'(io.LEDG), 32'(ledg_e));
    end

    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] pat, input logic [2:0] lm1, input logic st, input logic rp);
        sw = {4'b0, lm1, rp, st, pat, 1'b0};
    endtask

    task automatic run_frame(input logic [7:0] pat, input logic [2:0] lm1, input logic rp,
                             input int nbits, output logic [7:0] bits, output logic [7:0] flags);
        bits = '0;
        flags = '0;
        drive(pat, lm1, 1'b1, rp);
        edge_step();
        drive(pat, lm1, 1'b0, rp);
        for (int j = 0; j < nbits; j++) begin
            edge_step();
            bits     = {bits[6:0], io.LEDR[0]};
            flags[j] = io.LEDG[1];
        end
    endtask

    initial begin
        logic [7:0] b, f;
        repeat (2) edge_step();
        chk("reset_ledr", 32'(io.LEDR), 32'h0);
        chk("reset_ledg", 32'(io.LEDG), 32'h08);
        sw[0] = 1'b0;
        drive(8'hF0, 3'd7, 1'b1, 1'b0);
        edge_step();
        drive(8'hF0, 3'd7, 1'b0, 1'b0);
        repeat (3) edge_step();
        chk("t1_busy", 32'(io.LEDG[2]), 32'h1);
        sw[0] = 1'b1;
        #1;
        chk("t1_abort_ledr", 32'(io.LEDR), 32'h0);
        chk("t1_abort_ledg", 32'(io.LEDG), 32'h08);
        edge_step();
        sw[0] = 1'b0;
        edge_step();

        run_frame(8'hF0, 3'd7, 1'b0, 8, b, f);
        chk("t2_bits", 32'(b), 32'hF0);
        chk("t2_flag_e4", 32'(f[2]), 32'h0);
        chk("t2_flag_e5", 32'(f[3]), 32'h1);
        chk("t2_flag_e8", 32'(f[6]), 32'h0);
        chk("t2_flag_e9", 32'(f[7]), 32'h1);
        chk("t2_done", 32'(io.LEDG[0]), 32'h1);
        edge_step();
        chk("t2_idle", 32'(io.LEDG[3]), 32'h1);

        run_frame(8'hA5, 3'd7, 1'b0, 8, b, f);
        chk("t3_bits", 32'(b), 32'hA5);
        chk("t3_noflag", 32'(f), 32'h0);
        edge_step();

        drive(8'hC0, 3'd2, 1'b1, 1'b0);
        edge_step();
        chk("t4_left0", 32'(io.LEDR[12:10]), 32'd2);
        drive(8'hC0, 3'd2, 1'b0, 1'b0);
        edge_step();
        chk("t4_bit1", 32'(io.LEDR[0]), 32'h1);
        chk("t4_left1", 32'(io.LEDR[12:10]), 32'd1);
        edge_step();
        chk("t4_bit2", 32'(io.LEDR[0]), 32'h1);
        chk("t4_left2", 32'(io.LEDR[12:10]), 32'd0);
        edge_step();
        chk("t4_bit3", 32'(io.LEDR[0]), 32'h0);
        chk("t4_done", 32'(io.LEDG[0]), 32'h1);
        chk("t4_sreg", 32'(io.LEDR[9:2]), 32'h00);
        edge_step();

        drive(8'h0F, 3'd3, 1'b1, 1'b1);
        edge_step();
        drive(8'h0F, 3'd3, 1'b0, 1'b1);
        for (int j = 2; j <= 11; j++) begin
            edge_step();
            chk("t5_bit", 32'(io.LEDR[1:0]), 32'h2);
            if (j >= 5) chk("t5_flag", 32'(io.LEDG[1]), 32'h1);
        end
        drive(8'h0F, 3'd3, 1'b0, 1'b0);
        edge_step();
        chk("t5_notyet", 32'(io.LEDG[0]), 32'h0);
        edge_step();
        chk("t5_done", 32'(io.LEDG[0]), 32'h1);
        edge_step();

        drive(8'hC0, 3'd0, 1'b1, 1'b0);
        repeat (4) edge_step();
        chk("t6_hold_done", 32'(io.LEDG), 32'h01);
        chk("t6_hold_valid", 32'(io.LEDR[1]), 32'h0);
        drive(8'hC0, 3'd0, 1'b0, 1'b0);
        edge_step();
        chk("t6_release", 32'(io.LEDG[3]), 32'h1);

        drive(8'h81, 3'd3, 1'b1, 1'b0);
        edge_step();
        drive(8'h81, 3'd3, 1'b0, 1'b0);
        edge_step();
        b = {7'b0, io.LEDR[0]};
        drive(8'h81, 3'd3, 1'b1, 1'b0);
        edge_step();
        b = {b[6:0], io.LEDR[0]};
        drive(8'h81, 3'd3, 1'b0, 1'b0);
        edge_step();
        b = {b[6:0], io.LEDR[0]};
        edge_step();
        b = {b[6:0], io.LEDR[0]};
        chk("t6_pulse_bits", 32'(b), 32'h8);
        chk("t6_pulse_done", 32'(io.LEDG[0]), 32'h1);
        edge_step();
        chk("t6_pulse_idle", 32'(io.LEDG[3]), 32'h1);
        repeat (2) edge_step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
